// File: rtl/edge_scan_controller.sv
// Window scan sequencer for the 3-row sample buffer and Sobel compute stage.
// Optional watchdog on the FILL/CALC_WAIT waits is enabled with `define SCAN_WDOG_EN.
module edge_scan_controller #(
  parameter int PIX_W      = 20,
  parameter int DIM_W      = 12,
  parameter int STEP       = 2,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] image_width,
  input  logic [DIM_W-1:0] image_height,
  output logic [PIX_W-1:0] ED_rpixNum,
  output logic             fill_buff,
  input  logic             buff_filled,
  output logic             calc_start,
  input  logic             calc_done,
  output logic [PIX_W-1:0] out_pixNum,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_CALC_GO   = 3'd2,
    S_CALC_WAIT = 3'd3,
    S_ADVANCE   = 3'd4,
    S_RELEASE   = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t           state_q;
  state_t           state_nxt;

  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] col_q;
  logic [DIM_W-1:0] row_q;
  logic [PIX_W-1:0] row_base_q;
  logic [PIX_W-1:0] out_pix_q;
  logic             cfg_err_q;

  logic             cfg_ok;
  logic             last_col;
  logic             last_row;
  logic [DIM_W-1:0] col_lim;
  logic [DIM_W:0]   col_step;
  logic             clamp;

  logic             accept;
  logic             load_out;
  logic             step_win;
  logic             wdog_hit;
  logic             wdog_fire;

  assign cfg_ok   = (image_width >= DIM_W'(4)) && (image_height >= DIM_W'(3));
  assign col_lim  = width_q - DIM_W'(4);
  assign last_col = (col_q == col_lim);
  assign last_row = (row_q == (height_q - DIM_W'(3)));
  // Compare one bit wider so col+STEP cannot wrap on large widths.
  assign col_step = {1'b0, col_q} + (DIM_W+1)'(STEP);
  assign clamp    = (col_step > {1'b0, col_lim});

  assign ED_rpixNum = row_base_q + PIX_W'(col_q);
  assign out_pixNum = out_pix_q;
  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = cfg_err_q;

`ifdef SCAN_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_q;
  logic            wdog_run;

  assign wdog_run = (state_q == S_FILL) || (state_q == S_CALC_WAIT);
  assign wdog_hit = wdog_run && (wdog_q == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog_q <= '0;
    end else if (!wdog_run || (state_nxt != state_q)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end
`else
  // No watchdog: the waits in FILL and CALC_WAIT are unbounded.
  assign wdog_hit = (WDOG_LIMIT < 0);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    fill_buff  = 1'b0;
    calc_start = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    load_out   = 1'b0;
    step_win   = 1'b0;
    wdog_fire  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = cfg_ok ? S_FILL : S_FINISH;
        end
      end
      S_FILL: begin
        fill_buff = 1'b1;
        if (buff_filled) begin
          load_out  = 1'b1;
          state_nxt = S_CALC_GO;
        end else if (wdog_hit) begin
          wdog_fire = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CALC_GO: begin
        calc_start = 1'b1;
        state_nxt  = S_CALC_WAIT;
      end
      S_CALC_WAIT: begin
        if (calc_done) begin
          state_nxt = S_ADVANCE;
        end else if (wdog_hit) begin
          wdog_fire = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ADVANCE: begin
        if (last_col && last_row) begin
          state_nxt = S_FINISH;
        end else begin
          step_win  = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      // Never re-request a fill while the buffer still shows the old one.
      S_RELEASE: begin
        if (!buff_filled) begin
          state_nxt = S_FILL;
        end
      end
      S_FINISH: begin
        done      = !cfg_err_q;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (abort) begin
      state_nxt = S_IDLE;
      done      = 1'b0;
      accept    = 1'b0;
      load_out  = 1'b0;
      step_win  = 1'b0;
      wdog_fire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      out_pix_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        width_q    <= image_width;
        height_q   <= image_height;
        col_q      <= '0;
        row_q      <= '0;
        row_base_q <= '0;
        cfg_err_q  <= !cfg_ok;
      end
      if (wdog_fire) begin
        cfg_err_q <= 1'b1;
      end
      if (load_out) begin
        out_pix_q <= ED_rpixNum + PIX_W'(width_q) + PIX_W'(1);
      end
      // The final window of a row is clamped so the right edge is always covered.
      if (step_win) begin
        if (last_col) begin
          col_q      <= '0;
          row_q      <= row_q + DIM_W'(1);
          row_base_q <= row_base_q + PIX_W'(width_q);
        end else if (clamp) begin
          col_q <= col_lim;
        end else begin
          col_q <= col_q + DIM_W'(STEP);
        end
      end
    end
  end

endmodule
